// File: rtl/arbiter_bist_ctrl.sv
// arbiter_bist_ctrl: BIST sequencer for the 4-requester arbiter and its grant MISR.
// Ports: clk, rst (async, active-low); bist_start/bist_abort command; req_func functional
// requests; signature from the MISR; req_o to the arbiter; arb_rst/misr_rst sync resets;
// test_mode, bist_busy, bist_done, bist_pass status; sig_capt captured signature.
// Define BIST_SIG_CAPTURE_EN to register the signature into sig_capt at COMPARE exit;
// otherwise sig_capt is tied to 0.
module arbiter_bist_ctrl #(
  parameter int              NBIT      = 8,
  parameter logic [15:0]     NPAT      = 16'd255,
  parameter int              FLUSH_CYC = 2,
  parameter logic [7:0]      LFSR_SEED = 8'h01,
  parameter logic [NBIT-1:0] GOLDEN    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bist_start,
  input  logic            bist_abort,
  input  logic [3:0]      req_func,
  input  logic [NBIT-1:0] signature,
  output logic [3:0]      req_o,
  output logic            arb_rst,
  output logic            misr_rst,
  output logic            test_mode,
  output logic            bist_busy,
  output logic            bist_done,
  output logic            bist_pass,
  output logic [NBIT-1:0] sig_capt
);
  typedef enum logic [2:0] {IDLE, INIT, RUN, FLUSH, COMPARE, DONE} state_t;
  localparam logic [7:0]  SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] NPAT_M1  = (NPAT == 16'd0) ? 16'd0 : NPAT - 16'd1;
  localparam logic [15:0] FLUSH_M1 = 16'(FLUSH_CYC - 1);
  state_t      state, nxt;
  logic [15:0] cnt;
  logic [7:0]  lfsr, lfsr_nx;
  logic [3:0]  req_q;
  logic        last, idle_like;
  assign lfsr_nx   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign idle_like = (state == IDLE) || (state == DONE);
  // functional requests bypass the register so the arbiter sees them with no added latency
  assign req_o     = idle_like ? req_func : req_q;
  always_comb begin
    last = cnt == ((state == INIT) ? 16'd1 : (state == RUN) ? NPAT_M1 : FLUSH_M1);
    nxt  = (bist_abort && state != IDLE) ? IDLE :
           idle_like                     ? (bist_start ? INIT : state) :
           (state == COMPARE)            ? DONE :
           last                          ? state_t'(state + 3'd1) : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lfsr      <= SEED;
      req_q     <= '0;
      arb_rst   <= 1'b0;
      misr_rst  <= 1'b1;
      test_mode <= 1'b0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_pass <= 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
      sig_capt  <= '0;
`endif
    end else begin
      state     <= nxt;
      cnt       <= (nxt != state) ? 16'd0 : (&cnt) ? cnt : cnt + 16'd1;
      lfsr      <= (nxt == INIT) ? SEED : (state == RUN) ? lfsr_nx : lfsr;
      // req_q mirrors the LFSR value being presented during the coming RUN cycle
      req_q     <= (nxt != RUN) ? 4'h0 : (state == RUN) ? lfsr_nx[3:0] : lfsr[3:0];
      arb_rst   <= nxt == INIT;
      misr_rst  <= (nxt == IDLE) || (nxt == INIT) || (nxt == DONE);
      test_mode <= (nxt != IDLE) && (nxt != DONE);
      bist_busy <= (nxt != IDLE) && (nxt != DONE);
      bist_done <= nxt == DONE;
      bist_pass <= (nxt != DONE) ? 1'b0 : (state == COMPARE) ? (signature == GOLDEN) : bist_pass;
`ifdef BIST_SIG_CAPTURE_EN
      sig_capt  <= (state == COMPARE && nxt == DONE) ? signature :
                   (nxt == IDLE || nxt == INIT) ? '0 : sig_capt;
`endif
    end
  end
`ifndef BIST_SIG_CAPTURE_EN
  assign sig_capt = '0;
`endif
endmodule

// File: tb/tb_arbiter_bist_ctrl.sv
// tb_arbiter_bist_ctrl: directed self-checking bench for arbiter_bist_ctrl.
module tb_arbiter_bist_ctrl;
  logic       clk, rst, bist_start, bist_abort;
  logic [3:0] req_func, req_o;
  logic [7:0] signature, sig_capt;
  logic       arb_rst, misr_rst, test_mode, bist_busy, bist_done, bist_pass;
  int         n_chk = 0, n_pass = 0;
  logic [3:0] pat [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h3, 4'h7, 4'hE};
`ifdef BIST_SIG_CAPTURE_EN
  localparam logic [7:0] CAP_PASS = 8'h5C, CAP_FAIL = 8'h5D;
`else
  localparam logic [7:0] CAP_PASS = 8'h00, CAP_FAIL = 8'h00;
`endif
  arbiter_bist_ctrl #(.NBIT(8), .NPAT(16'd16), .FLUSH_CYC(2), .LFSR_SEED(8'h01), .GOLDEN(8'h5C)) dut (
    .clk(clk), .rst(rst), .bist_start(bist_start), .bist_abort(bist_abort),
    .req_func(req_func), .signature(signature), .req_o(req_o), .arb_rst(arb_rst),
    .misr_rst(misr_rst), .test_mode(test_mode), .bist_busy(bist_busy),
    .bist_done(bist_done), .bist_pass(bist_pass), .sig_capt(sig_capt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_start(input string tag, input int n);
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    check({tag, " e0 arb_rst"}, 32'(arb_rst), 1);
    check({tag, " e0 busy"}, 32'(bist_busy), 1);
    check({tag, " e0 test_mode"}, 32'(test_mode), 1);
    check({tag, " e0 req_o"}, 32'(req_o), 0);
    check({tag, " e0 done"}, 32'(bist_done), 0);
    check({tag, " e0 pass"}, 32'(bist_pass), 0);
    tick();
    check({tag, " e1 arb_rst"}, 32'(arb_rst), 1);
    check({tag, " e1 misr_rst"}, 32'(misr_rst), 1);
    tick();
    check({tag, " e2 arb_rst"}, 32'(arb_rst), 0);
    check({tag, " e2 misr_rst"}, 32'(misr_rst), 0);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s run%0d req_o", tag, i), 32'(req_o), 32'(pat[i]));
      tick();
    end
  endtask
  initial begin
    rst = 1'b0; bist_start = 1'b0; bist_abort = 1'b0; req_func = 4'hA; signature = 8'h5C;
    repeat (2) tick();
    check("rst req_o", 32'(req_o), 32'hA);
    check("rst misr_rst", 32'(misr_rst), 1);
    check("rst arb_rst", 32'(arb_rst), 0);
    check("rst test_mode", 32'(test_mode), 0);
    check("rst busy", 32'(bist_busy), 0);
    check("rst done", 32'(bist_done), 0);
    check("rst pass", 32'(bist_pass), 0);
    check("rst sig_capt", 32'(sig_capt), 0);
    @(negedge clk) rst = 1'b1;
    req_func = 4'h5;
    repeat (2) tick();
    check("idle busy", 32'(bist_busy), 0);
    check("idle req_o", 32'(req_o), 32'h5);
    run_start("pass", 8);
    repeat (10) tick();
    check("pass e20 done", 32'(bist_done), 0);
    check("pass e20 busy", 32'(bist_busy), 1);
    check("pass e20 req_o", 32'(req_o), 0);
    tick();
    check("pass e21 done", 32'(bist_done), 1);
    check("pass e21 busy", 32'(bist_busy), 0);
    check("pass e21 pass", 32'(bist_pass), 1);
    check("pass e21 sig_capt", 32'(sig_capt), 32'(CAP_PASS));
    check("pass e21 test_mode", 32'(test_mode), 0);
    check("pass e21 misr_rst", 32'(misr_rst), 1);
    check("pass e21 req_o", 32'(req_o), 32'h5);
    tick();
    check("pass hold", 32'(bist_pass), 1);
    signature = 8'h5D;
    run_start("fail", 8);
    repeat (10) tick();
    check("fail e20 done", 32'(bist_done), 0);
    tick();
    check("fail e21 done", 32'(bist_done), 1);
    check("fail e21 pass", 32'(bist_pass), 0);
    check("fail e21 sig_capt", 32'(sig_capt), 32'(CAP_FAIL));
    run_start("abort", 4);
    check("abort run4 req_o", 32'(req_o), 32'(pat[4]));
    bist_abort = 1'b1;
    bist_start = 1'b1;
    tick();
    bist_abort = 1'b0;
    bist_start = 1'b0;
    check("abort busy", 32'(bist_busy), 0);
    check("abort test_mode", 32'(test_mode), 0);
    check("abort done", 32'(bist_done), 0);
    check("abort req_o", 32'(req_o), 32'h5);
    check("abort misr_rst", 32'(misr_rst), 1);
    check("abort sig_capt", 32'(sig_capt), 0);
    tick();
    check("abort stays idle", 32'(bist_busy), 0);
    run_start("flush", 8);
    repeat (9) tick();
    check("flush busy", 32'(bist_busy), 1);
    check("flush req_o", 32'(req_o), 0);
    check("flush misr_rst", 32'(misr_rst), 0);
    #2 rst = 1'b0;
    #1;
    check("async busy", 32'(bist_busy), 0);
    check("async test_mode", 32'(test_mode), 0);
    check("async misr_rst", 32'(misr_rst), 1);
    check("async arb_rst", 32'(arb_rst), 0);
    check("async req_o", 32'(req_o), 32'h5);
    check("async done", 32'(bist_done), 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) tick();
    check("post rst idle", 32'(bist_busy), 0);
    run_start("rerun", 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
